// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: tag pipeline forwarding selects and load-use stall; FWD_STALL_COUNT_EN adds a saturating stall counter
module forward_hazard_unit #(
  parameter int REG_BITS = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_LAT = 2,
  localparam int SELW = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                flush,
  output logic [SELW-1:0]     fwd_rs,
  output logic [SELW-1:0]     fwd_rt,
  output logic                stall,
  output logic [15:0]         stall_count
);
  logic [DEPTH:1] v, m;
  logic [REG_BITS-1:0] r [1:DEPTH];
  logic rs_nr, rt_nr;
  // scan oldest to youngest so the youngest match wins, including its readiness
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    rs_nr = 1'b0;
    rt_nr = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v[k] && r[k] == id_rs && id_rs != '0) begin
        fwd_rs = SELW'(k);
        rs_nr = m[k] && k < LOAD_LAT;
      end
      if (v[k] && r[k] == id_rt && id_rt != '0) begin
        fwd_rt = SELW'(k);
        rt_nr = m[k] && k < LOAD_LAT;
      end
    end
    stall = id_valid & ~flush & (rs_nr | rt_nr);
  end
  // shift tags one stage per cycle; stalled or flushed ID enters as a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      m <= '0;
      for (int k = 1; k <= DEPTH; k++) r[k] <= '0;
    end else begin
      v <= {v[DEPTH-1:1], id_valid & id_regwrite & ~stall & ~flush};
      m <= {m[DEPTH-1:1], id_memread};
      for (int k = DEPTH; k >= 2; k--) r[k] <= r[k-1];
      r[1] <= id_rd;
    end
  end
`ifdef FWD_STALL_COUNT_EN
  logic [15:0] cnt;
  // count stall cycles, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (stall && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign stall_count = cnt;
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed scoreboard bench over default, 5/3 and 7/7 configurations
module tb_forward_hazard_unit;
`ifdef FWD_STALL_COUNT_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif
  logic clk = 0, rst = 1, id_valid = 0, id_regwrite = 0, id_memread = 0, flush = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic [1:0] rs0, rt0;
  logic [2:0] rs1, rt1, rs2, rt2;
  logic st0, st1, st2;
  logic [15:0] c0, c1, c2;
  int checks = 0, fails = 0;
  typedef struct {int sel; logic [2:0] rs, rt; logic st; logic [15:0] cnt; string name;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  forward_hazard_unit u0 (.clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .fwd_rs(rs0), .fwd_rt(rt0), .stall(st0), .stall_count(c0));
  forward_hazard_unit #(.DEPTH(5), .LOAD_LAT(3)) u1 (.clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .fwd_rs(rs1), .fwd_rt(rt1), .stall(st1), .stall_count(c1));
  forward_hazard_unit #(.DEPTH(7), .LOAD_LAT(7)) u2 (.clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .fwd_rs(rs2), .fwd_rt(rt2), .stall(st2), .stall_count(c2));
  task automatic drive(input logic r, v, input logic [4:0] s, t, d, input logic w, mm, f);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs = s; id_rt = t; id_rd = d; id_regwrite = w; id_memread = mm; flush = f;
  endtask
  task automatic step(input logic r, v, input logic [4:0] s, t, d, input logic w, mm, f,
                      input int sel, input logic [2:0] ers, ert, input logic est, input int ecnt, input string nm);
    exp_t e;
    drive(r, v, s, t, d, w, mm, f);
    e.sel = sel; e.rs = ers; e.rt = ert; e.st = est; e.cnt = 16'(ecnt); e.name = nm;
    q.push_back(e);
  endtask
  // monitor: every cycle with a pending expectation, compare the selected instance
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0] ars, art;
      logic ast, ok;
      logic [15:0] ac;
      e = q.pop_front();
      ars = e.sel == 0 ? {1'b0, rs0} : e.sel == 1 ? rs1 : rs2;
      art = e.sel == 0 ? {1'b0, rt0} : e.sel == 1 ? rt1 : rt2;
      ast = e.sel == 0 ? st0 : e.sel == 1 ? st1 : st2;
      ac = e.sel == 0 ? c0 : e.sel == 1 ? c1 : c2;
      ok = e.sel == 2 ? ac == e.cnt : {ars, art, ast, ac} == {e.rs, e.rt, e.st, e.cnt};
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL %s: got rs=%0d rt=%0d stall=%0d cnt=%0d, want rs=%0d rt=%0d stall=%0d cnt=%0d",
                 e.name, ars, art, ast, ac, e.rs, e.rt, e.st, e.cnt);
      end
    end
  end
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(0, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, "add_r3");
    step(0, 1, 3, 4, 6, 0, 0, 0, 0, 1, 0, 0, 0, "alu_fwd1");
    step(0, 1, 3, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, "alu_fwd2");
    step(0, 0, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, "alu_fwd3");
    step(0, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, "lw_r5");
    step(0, 1, 2, 5, 8, 1, 0, 0, 0, 0, 1, 1, 0, "load_use_stall");
    step(0, 1, 2, 5, 8, 1, 0, 0, 0, 0, 2, 0, C, "load_use_go");
    step(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, C, "add_r7_a");
    step(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, C, "add_r9");
    step(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, C, "add_r7_b");
    step(0, 1, 7, 9, 0, 1, 0, 0, 0, 1, 2, 0, C, "shadow_alu");
    step(0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, C, "r0_writer");
    step(0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 1, C, "shadow_load_stall");
    step(0, 1, 7, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2 * C, "shadow_load_go");
    step(0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 2 * C, "lw_r5_flush");
    step(0, 1, 0, 5, 10, 1, 0, 1, 0, 0, 1, 0, 2 * C, "flush_no_stall");
    step(0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2 * C, "flush_bubble");
    step(0, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 2 * C, "lw_r6");
    step(0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2 * C, "pre_rst_stall");
    step(1, 1, 6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 3 * C, "rst_cycle");
    step(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
    step(0, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 0, "d5_lw");
    step(0, 1, 5, 0, 11, 1, 0, 0, 1, 1, 0, 1, 0, "d5_stall1");
    step(0, 1, 5, 0, 11, 1, 0, 0, 1, 2, 0, 1, C, "d5_stall2");
    step(0, 1, 5, 0, 11, 1, 0, 0, 1, 3, 0, 0, 2 * C, "d5_go");
    step(0, 1, 11, 5, 0, 0, 0, 0, 1, 1, 4, 0, 2 * C, "d5_two_src");
    drive(1, 1, 5, 0, 5, 1, 1, 0);
    repeat (700) drive(0, 1, 5, 0, 5, 1, 1, 0);
    step(0, 1, 5, 0, 5, 1, 1, 0, 2, 0, 0, 0, 600 * C, "sat_partial");
    repeat (76461 - 701) drive(0, 1, 5, 0, 5, 1, 1, 0);
    step(0, 1, 5, 0, 5, 1, 1, 0, 2, 0, 0, 0, C * 65535, "sat_reach");
    repeat (100) drive(0, 1, 5, 0, 5, 1, 1, 0);
    step(0, 1, 5, 0, 5, 1, 1, 0, 2, 0, 0, 0, C * 65535, "sat_hold");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter REG_BITS, default 5: register-index width.
REQ-002 SHALL have parameter DEPTH, default 3: in-flight writer stages tracked (stage 1 = EX … stage DEPTH = WB), legal 2..7.
REQ-003 SHALL have parameter LOAD_LAT, default 2: first stage at which load data is forwardable, legal 1..DEPTH.
REQ-004 SHALL use the clock and reset chosen for this block: one clock, reset synchronous and active-high.
REQ-005 SHALL have clk  in  1  rising-edge clock.
REQ-006 SHALL have rst  in  1  synchronous active-high reset.
REQ-007 SHALL have id_valid  in  1  ID holds a real instruction.
REQ-008 SHALL have id_rs, id_rt  in  REG_BITS each  ID source registers.
REQ-009 SHALL have id_rd  in  REG_BITS  ID destination register.
REQ-010 SHALL have id_regwrite, id_memread  in  1 each  ID writes a register / ID is a load.
REQ-011 SHALL have flush  in  1  squash the ID instruction.
REQ-012 SHALL have fwd_rs, fwd_rt  out  SELW=$clog2(DEPTH+1) each  source stage index; 0 = register file.
REQ-013 SHALL have stall  out  1  hold PC/IF/ID this cycle.
REQ-014 SHALL have stall_count  out  16  saturating stall-cycle count.

Function
REQ-015 SHALL keep a DEPTH-entry tag pipeline; each entry holds valid, rd, memread.
REQ-016 SHALL shift every cycle: entry k takes entry k-1 for k = 2..DEPTH; entry DEPTH's old content is dropped.
REQ-017 SHALL load entry 1 with {id_valid & id_regwrite & ~stall & ~flush, id_rd, id_memread}; otherwise it loads a bubble (valid = 0).
REQ-018 SHALL treat an entry as matching source s when valid = 1, rd == s and s != 0.
REQ-019 SHALL drive fwd_rs (and fwd_rt likewise) combinationally with the lowest-numbered (youngest) matching stage index, else 0.
REQ-020 SHALL treat a matching entry with memread = 1 at stage k < LOAD_LAT as not ready.
REQ-021 SHALL assert stall combinationally when id_valid = 1, flush = 0, and the youngest match for rs or rt is not ready.
REQ-022 SHALL still drive fwd_* with the youngest-match index while stalled; the consumer ignores fwd_* during stall.
REQ-023 SHALL ignore older matches shadowed by a younger match, including a younger non-ready load.
REQ-024 SHALL give flush priority over stall: flush = 1 forces stall = 0 and puts a bubble in entry 1.
REQ-025 SHALL bound any stall to LOAD_LAT-1 consecutive cycles, since stalls insert bubbles and the load advances one stage per cycle.
REQ-026 SHALL add 1 to stall_count on each cycle with stall = 1 and hold it at 16'hFFFF once reached.

Reset
REQ-027 SHALL, while rst = 1 at a clock edge, clear all entries to valid = 0, rd = 0, memread = 0 and clear stall_count to 0.
REQ-028 SHALL drive fwd_rs = fwd_rt = 0 and stall = 0 in the cycle after reset and until a writer is captured.
REQ-029 SHALL discard all in-flight tags on a reset mid-operation; rst has priority over flush and stall.

Configuration
REQ-030 SHALL compile the stall counter only when macro FWD_STALL_COUNT_EN is defined.
REQ-031 SHALL, when FWD_STALL_COUNT_EN is undefined, tie stall_count to 0, keep the port, and contain no counter flops.

Verification
REQ-032 SHALL cover ALU chain: ADD r3 in ID, then next ID reads r3 -> fwd_rs = 1, stall = 0; one cycle later with no other writer -> fwd_rs = 2.
REQ-033 SHALL cover load-use (default parameters): LW r5, then next ID reads rt = r5 -> stall = 1 for exactly 1 cycle, fwd_rt = 1; next cycle fwd_rt = 2, stall = 0, stall_count = 1.
REQ-034 SHALL cover shadowing: r7 written at stages 3 and 1 (ALU) -> fwd_rs = 1; r0 written at stage 1 -> fwd = 0, no stall.
REQ-035 SHALL cover flush: a load-use pair with flush = 1 on the consumer cycle -> stall = 0, entry 1 becomes a bubble, stall_count unchanged.
REQ-036 SHALL cover reset mid-stall: stall = 1, then rst pulsed -> next cycle all fwd = 0, stall = 0, stall_count = 0.
REQ-037 SHALL cover DEPTH = 5, LOAD_LAT = 3 plus saturation: load-use -> 2-cycle stall; force 70000 stall cycles with the macro defined -> stall_count = 16'hFFFF; macro undefined -> stall_count = 0.
